// File: rtl/ext_pkg.sv
// ext_pkg: shared extension-mode encodings for extend_pipe and ext_mode_mux
package ext_pkg;
  typedef enum logic [1:0] {
    MODE_ZERO   = 2'b00,
    MODE_SIGN   = 2'b01,
    MODE_UPPER  = 2'b10,
    MODE_BRANCH = 2'b11
  } mode_e;
endpackage

// File: rtl/extend_pipe_if.sv
// extend_pipe_if: upstream valid_i/ready_o/data_i/mode_i, downstream valid_o/ready_i/data_o, cnt_o transfer count
interface extend_pipe_if #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
);
  logic             valid_i;
  logic             ready_o;
  logic [IN_W-1:0]  data_i;
  logic [1:0]       mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [OUT_W-1:0] data_o;
  logic [CNT_W-1:0] cnt_o;
  modport master (
    output valid_i, data_i, mode_i, ready_i,
    input  ready_o, valid_o, data_o, cnt_o
  );
  modport slave (
    input  valid_i, data_i, mode_i, ready_i,
    output ready_o, valid_o, data_o, cnt_o
  );
endinterface

// File: rtl/ext_mode_mux.sv
// ext_mode_mux: combinational immediate extender; data_i (IN_W) + mode_i -> data_o (OUT_W) per ext_pkg mode
module ext_mode_mux
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  data_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o
);
  logic [OUT_W-1:0] zext, sext, upper;
  logic [OUT_W-3:0] sext_b;
  assign zext   = OUT_W'(data_i);
  assign sext   = OUT_W'($signed(data_i));
  assign sext_b = (OUT_W-2)'($signed(data_i));
  assign upper  = {data_i, (OUT_W-IN_W)'(0)};
  always_comb begin
    data_o = mode_i == MODE_ZERO  ? zext  :
             mode_i == MODE_SIGN  ? sext  :
             mode_i == MODE_UPPER ? upper :
                                    {sext_b, 2'b00};
  end
endmodule

// File: rtl/extend_pipe.sv
// extend_pipe: immediate extender behind a 2-entry skid buffer; ports clk_i, rst_i (async high), io (extend_pipe_if.slave)
module extend_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int CNT_W = 8
) (
  input logic          clk_i,
  input logic          rst_i,
  extend_pipe_if.slave io
);
  if (OUT_W < IN_W + 2) begin : g_bad_w
    $error("extend_pipe: OUT_W must be >= IN_W+2");
  end
  logic [OUT_W-1:0] res, out_data, skid_data;
  logic             out_valid, skid_valid, rdy_q, in_xfer, out_xfer;
  logic [CNT_W-1:0] cnt;
  ext_mode_mux #(.IN_W(IN_W), .OUT_W(OUT_W)) u_mux (
    .data_i(io.data_i),
    .mode_i(io.mode_i),
    .data_o(res)
  );
  // rdy_q keeps ready_o low through reset and rises on the first edge after it
  assign io.ready_o = rdy_q & ~skid_valid;
  assign io.valid_o = out_valid;
  assign io.data_o  = out_data;
  assign io.cnt_o   = cnt;
  assign in_xfer    = io.valid_i & io.ready_o;
  assign out_xfer   = out_valid & io.ready_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdy_q      <= 1'b0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
      skid_data  <= '0;
      cnt        <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (out_xfer) cnt <= cnt + 1'b1;
      // in_xfer implies SKID is empty, so only OUT can be occupied here
      if (in_xfer && (!out_valid || out_xfer)) begin
        out_data  <= res;
        out_valid <= 1'b1;
      end else if (in_xfer) begin
        skid_data  <= res;
        skid_valid <= 1'b1;
      end else if (out_xfer) begin
        out_valid  <= skid_valid;
        skid_valid <= 1'b0;
        if (skid_valid) out_data <= skid_data;
      end
    end
  end
endmodule

// File: doc/extend_pipe.md
EXTEND_PIPE -- requirements
Module: extend_pipe

Interface
REQ-001 Parameter IN_W, default 16, immediate input width.
REQ-002 Parameter OUT_W, default 32, result width; SHALL satisfy OUT_W >= IN_W+2, else elaboration error.
REQ-003 Parameter CNT_W, default 8, width of transfer counter.
REQ-004 Port clk_i  input  1  single clock, all state on rising edge.
REQ-005 Port rst_i  input  1  asynchronous, active-high reset.
REQ-006 Port valid_i  input  1  upstream item present.
REQ-007 Port ready_o  output  1  block can accept an item this cycle.
REQ-008 Port data_i  input  IN_W  immediate field.
REQ-009 Port mode_i  input  2  extension mode, sampled with data_i.
REQ-010 Port valid_o  output  1  result present on data_o.
REQ-011 Port ready_i  input  1  downstream accepts result.
REQ-012 Port data_o  output  OUT_W  extended result.
REQ-013 Port cnt_o  output  CNT_W  count of completed output transfers.

Function
REQ-014 Mode 00 ZERO: data_o = zero-extension of data_i to OUT_W.
REQ-015 Mode 01 SIGN: data_o = data_i sign-extended from bit IN_W-1.
REQ-016 Mode 10 UPPER: data_o = data_i in bits [OUT_W-1 : OUT_W-IN_W], lower bits zero.
REQ-017 Mode 11 BRANCH: data_o = (sign-extended data_i) shifted left 2, top 2 bits discarded, bits [1:0] zero.
REQ-018 Input transfer occurs when valid_i and ready_o both high at a rising edge; output transfer when valid_o and ready_i both high.
REQ-019 Storage: one output register (OUT) driving data_o/valid_o plus one skid register (SKID); result computed combinationally from data_i/mode_i and captured at input transfer.
REQ-020 ready_o SHALL equal NOT skid_valid, driven from registers only (no combinational path from ready_i).
REQ-021 Latency: with OUT empty, an item accepted at edge N appears on data_o with valid_o high after edge N, i.e. one cycle.
REQ-022 Accepted item loads OUT if OUT is empty or OUT transfers in the same cycle; otherwise loads SKID.
REQ-023 On output transfer with SKID full, SKID moves to OUT and SKID empties; ready_o rises next cycle.
REQ-024 Full: OUT and SKID both valid -> ready_o low, no input accepted, contents held stable.
REQ-025 Empty: valid_o low; data_o holds last value (don't-care to downstream).
REQ-026 Simultaneous input and output transfer with SKID empty: new item replaces OUT, valid_o stays high, no bubble.
REQ-027 Items SHALL leave in acceptance order; none dropped or duplicated.
REQ-028 While valid_o high and ready_i low, data_o and valid_o SHALL not change.
REQ-029 cnt_o increments by 1 per output transfer, wraps 2^CNT_W-1 -> 0.

Reset
REQ-030 rst_i high asynchronously clears OUT/SKID valid flags, data_o to 0, cnt_o to 0.
REQ-031 During reset ready_o SHALL be 0; ready_o becomes 1 on first clock edge after rst_i deasserts.
REQ-032 Reset mid-operation discards all buffered items; no output transfer of pre-reset data afterwards.

Structure
REQ-033 Mode encodings (ZERO=00, SIGN=01, UPPER=10, BRANCH=11) SHALL be constants in shared package ext_pkg, reused by the decoder.
REQ-034 Combinational mode mux SHALL be sub-module ext_mode_mux (params IN_W, OUT_W); handshake and registers stay in extend_pipe.

Verification (IN_W=16, OUT_W=32, CNT_W=8, ready_i=1 unless stated)
REQ-035 ZERO 0x8001 -> data_o 0x00008001 one cycle later; SIGN 0x8001 -> 0xFFFF8001; SIGN 0x7FFF -> 0x00007FFF.
REQ-036 UPPER 0x1234 -> 0x12340000; BRANCH 0xFFFF -> 0xFFFFFFFC; BRANCH 0x0004 -> 0x00000010.
REQ-037 ready_i=0, valid_i high for items A,B,C back-to-back -> A,B accepted, ready_o low on C; ready_i=1 -> A,B,C out in order, cnt_o=3.
REQ-038 Continuous valid_i and ready_i for 300 items -> one result per cycle, no bubbles, cnt_o=300 mod 256=44.
REQ-039 Reset asserted with OUT and SKID full -> valid_o=0, ready_o=0, cnt_o=0 immediately; after release no stale item emitted.
